// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, issues single-outstanding imem requests,
// buffers responses in a 2-entry queue and drives the IF/ID pipeline register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stall_f,
  input  logic        i_stall_d,
  input  logic        i_flush_d,
  input  logic        i_pcsrc_e,
  input  logic [31:0] i_pc_target_e,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_if_id_instr,
  output logic [31:0] o_if_id_pc,
  output logic [31:0] o_if_id_pc4,
  output logic        o_if_id_valid,
  output logic        o_fetch_empty
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_f, pc_f_nxt, pc_req;
  logic [31:0] q_pc    [2];
  logic [31:0] q_instr [2];
  logic [1:0]  count;
  logic        wr_ptr, rd_ptr;
  logic        issue, push, pop, queue_empty;

  assign queue_empty   = (count == 2'd0);
  assign pop           = ~i_flush_d & ~i_stall_d & ~queue_empty;
  assign o_imem_req    = issue;
  assign o_imem_addr   = pc_f;
  assign o_fetch_empty = queue_empty;

  always_comb begin
    issue     = 1'b0;
    push      = 1'b0;
    state_nxt = state;
    pc_f_nxt  = pc_f;
    case (state)
      S_REQ: begin
        issue = (count < 2'd2) & ~i_stall_f & ~i_pcsrc_e;
        // A grant seen alongside a redirect belongs to the old path; its response must be eaten.
        if (i_pcsrc_e && i_imem_gnt) begin
          state_nxt = S_DROP;
        end else if (issue && i_imem_gnt) begin
          pc_f_nxt  = pc_f + 32'd4;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_imem_rvalid) begin
          push      = ~i_pcsrc_e;
          state_nxt = S_REQ;
        end else if (i_pcsrc_e) begin
          state_nxt = S_DROP;
        end
      end
      S_DROP: begin
        if (i_imem_rvalid) state_nxt = S_REQ;
      end
      default: state_nxt = S_REQ;
    endcase
    if (i_pcsrc_e) pc_f_nxt = i_pc_target_e;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= S_REQ;
      pc_f   <= RESET_PC;
      pc_req <= '0;
    end else begin
      state <= state_nxt;
      pc_f  <= pc_f_nxt;
      if (issue && i_imem_gnt) pc_req <= pc_f;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else if (i_pcsrc_e) begin
      count  <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      if (push && !pop)      count <= count + 2'd1;
      else if (pop && !push) count <= count - 2'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      q_pc[wr_ptr]    <= pc_req;
      q_instr[wr_ptr] <= i_imem_rdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_if_id_instr <= NOP_INSTR;
      o_if_id_pc    <= '0;
      o_if_id_pc4   <= 32'd4;
      o_if_id_valid <= 1'b0;
    end else if (i_flush_d || (!i_stall_d && queue_empty)) begin
      o_if_id_instr <= NOP_INSTR;
      o_if_id_pc    <= '0;
      o_if_id_pc4   <= 32'd4;
      o_if_id_valid <= 1'b0;
    end else if (!i_stall_d) begin
      o_if_id_instr <= q_instr[rd_ptr];
      o_if_id_pc    <= q_pc[rd_ptr];
      o_if_id_pc4   <= q_pc[rd_ptr] + 32'd4;
      o_if_id_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random traffic against a
// transaction-level model (SV queue for the buffer, outstanding/stale flags for the FSM).
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_f = 1'b0, stall_d = 1'b0, flush_d = 1'b0, pcsrc = 1'b0;
  logic [31:0] target = '0;
  logic        gnt = 1'b0, rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic        req, valid, empty;
  logic [31:0] addr, instr, pc, pc4;

  fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall_f(stall_f), .i_stall_d(stall_d),
    .i_flush_d(flush_d), .i_pcsrc_e(pcsrc), .i_pc_target_e(target),
    .o_imem_req(req), .o_imem_addr(addr), .i_imem_gnt(gnt),
    .i_imem_rvalid(rvalid), .i_imem_rdata(rdata),
    .o_if_id_instr(instr), .o_if_id_pc(pc), .o_if_id_pc4(pc4),
    .o_if_id_valid(valid), .o_fetch_empty(empty)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // memory responder
  bit          mem_pend = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = '0;
  int unsigned gnt_pct = 100;
  int unsigned lat_lo = 1, lat_hi = 1;
  bit          force_gnt = 1'b0;
  bit          fixed_en = 1'b0;
  logic [31:0] fixed_data = '0;

  // reference model
  logic [31:0] m_pc;
  logic [63:0] m_q[$];
  bit          m_out, m_stale;
  logic [31:0] m_outpc, m_instr, m_ifpc;
  bit          m_valid;

  logic        obs_req, exp_req;
  logic [31:0] obs_addr, exp_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic m_reset();
    m_pc = RST_PC; m_q.delete(); m_out = 1'b0; m_stale = 1'b0; m_outpc = '0;
    m_instr = NOP; m_ifpc = '0; m_valid = 1'b0;
  endtask

  task automatic model_edge();
    logic [63:0] head;
    bit          pop_ok, do_push;
    pop_ok  = !flush_d && !stall_d && (m_q.size() > 0);
    do_push = m_out && !m_stale && rvalid && !pcsrc;
    if (flush_d) begin
      m_instr = NOP; m_ifpc = '0; m_valid = 1'b0;
    end else if (!stall_d) begin
      if (m_q.size() > 0) begin
        head = m_q[0]; m_instr = head[31:0]; m_ifpc = head[63:32]; m_valid = 1'b1;
      end else begin
        m_instr = NOP; m_ifpc = '0; m_valid = 1'b0;
      end
    end
    if (pcsrc) m_q.delete();
    else begin
      if (pop_ok) void'(m_q.pop_front());
      if (do_push) m_q.push_back({m_outpc, rdata});
    end
    if (!m_out) begin
      if (pcsrc && gnt) begin
        m_out = 1'b1; m_stale = 1'b1;
      end else if (exp_req && gnt) begin
        m_out = 1'b1; m_stale = 1'b0; m_outpc = m_pc; m_pc = m_pc + 32'd4;
      end
    end else if (rvalid) m_out = 1'b0;
    else if (pcsrc) m_stale = 1'b1;
    if (pcsrc) m_pc = target;
  endtask

  // One clock: drive memory side at negedge, sample combinational outputs, advance model at posedge.
  task automatic step();
    @(negedge clk);
    rvalid = 1'b0; gnt = 1'b0;
    if (mem_pend) begin
      if (mem_cnt <= 1) begin
        rvalid = 1'b1;
        rdata  = fixed_en ? fixed_data : mem_word(mem_addr);
      end else mem_cnt--;
    end
    #1;
    obs_req  = req;
    obs_addr = addr;
    exp_req  = !m_out && (m_q.size() < 2) && !stall_f && !pcsrc;
    exp_addr = m_pc;
    if (!mem_pend && (force_gnt || (req && ($urandom_range(99) < gnt_pct)))) gnt = 1'b1;
    @(posedge clk);
    model_edge();
    if (rvalid) mem_pend = 1'b0;
    if (gnt) begin
      mem_pend = 1'b1; mem_cnt = int'($urandom_range(lat_hi, lat_lo)); mem_addr = obs_addr;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++; if (instr !== NOP) begin n_err++; $display("FAIL reset_instr: got %h expected %h", instr, NOP); end
    n_vec++; if (pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h expected 0", pc); end
    n_vec++; if (pc4 !== 32'h4) begin n_err++; $display("FAIL reset_pc4: got %h expected 4", pc4); end
    n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", valid); end
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b expected 1", empty); end
    rst_n = 1'b1;
    m_reset();
    #1;
    n_vec++; if (req !== 1'b1) begin n_err++; $display("FAIL reset_req: got %b expected 1", req); end
    n_vec++; if (addr !== RST_PC) begin n_err++; $display("FAIL reset_addr: got %h expected %h", addr, RST_PC); end
  endtask

  task automatic test_first_fetch();
    fixed_en = 1'b1; fixed_data = 32'hAABB_CCDD; gnt_pct = 100; lat_lo = 1; lat_hi = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++; if (obs_req !== exp_req) begin n_err++; $display("FAIL ff_req[%0d]: got %b expected %b", i, obs_req, exp_req); end
      n_vec++; if (obs_addr !== exp_addr) begin n_err++; $display("FAIL ff_addr[%0d]: got %h expected %h", i, obs_addr, exp_addr); end
      n_vec++; if (valid !== m_valid) begin n_err++; $display("FAIL ff_valid[%0d]: got %b expected %b", i, valid, m_valid); end
    end
    n_vec++; if (instr !== 32'hAABB_CCDD) begin n_err++; $display("FAIL ff_instr: got %h expected aabbccdd", instr); end
    n_vec++; if (pc !== 32'h100) begin n_err++; $display("FAIL ff_pc: got %h expected 100", pc); end
    n_vec++; if (pc4 !== 32'h104) begin n_err++; $display("FAIL ff_pc4: got %h expected 104", pc4); end
    n_vec++; if (valid !== 1'b1) begin n_err++; $display("FAIL ff_valid: got %b expected 1", valid); end
    n_vec++; if (obs_addr !== 32'h104) begin n_err++; $display("FAIL ff_next_addr: got %h expected 104", obs_addr); end
    fixed_en = 1'b0;
  endtask

  task automatic test_stall();
    logic [31:0] instr_s, pc_s;
    stall_d = 1'b1;
    for (int k = 0; k < 10 && m_q.size() != 1; k++) step();
    n_vec++; if (empty !== 1'b0) begin n_err++; $display("FAIL stall_fill: got empty=%b expected 0 (timeout)", empty); end
    stall_f = 1'b1;
    instr_s = instr; pc_s = pc;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++; if (obs_req !== 1'b0) begin n_err++; $display("FAIL stall_req[%0d]: got %b expected 0", i, obs_req); end
      n_vec++; if (instr !== instr_s || pc !== pc_s) begin n_err++; $display("FAIL stall_hold[%0d]: got %h@%h expected %h@%h", i, instr, pc, instr_s, pc_s); end
      n_vec++; if (empty !== 1'b0) begin n_err++; $display("FAIL stall_count[%0d]: got empty=%b expected 0", i, empty); end
    end
    stall_f = 1'b0; stall_d = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_vec++; if (obs_req !== exp_req || obs_addr !== exp_addr) begin n_err++; $display("FAIL stall_resume[%0d]: got req=%b addr=%h expected req=%b addr=%h", i, obs_req, obs_addr, exp_req, exp_addr); end
      n_vec++; if (instr !== m_instr || pc !== m_ifpc || valid !== m_valid) begin n_err++; $display("FAIL stall_ifid[%0d]: got %h@%h v%b expected %h@%h v%b", i, instr, pc, valid, m_instr, m_ifpc, m_valid); end
    end
  endtask

  task automatic test_queue_full();
    logic [31:0] first_pc;
    lat_lo = 1; lat_hi = 2;
    stall_d = 1'b1;
    for (int k = 0; k < 20 && m_q.size() != 2; k++) step();
    n_vec++; if (m_q.size() != 2 || empty !== 1'b0) begin n_err++; $display("FAIL qfull_fill: got empty=%b expected queue of 2 (timeout)", empty); end
    for (int i = 0; i < 2; i++) begin
      step();
      n_vec++; if (obs_req !== 1'b0) begin n_err++; $display("FAIL qfull_req[%0d]: got %b expected 0", i, obs_req); end
    end
    first_pc = m_q[0][63:32];
    stall_d = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i < 2) begin
        n_vec++; if (pc !== first_pc + 32'(4 * i) || valid !== 1'b1) begin n_err++; $display("FAIL qfull_order[%0d]: got pc=%h v%b expected pc=%h v1", i, pc, valid, first_pc + 32'(4 * i)); end
      end
      n_vec++; if (instr !== m_instr || pc !== m_ifpc || pc4 !== m_ifpc + 32'd4 || valid !== m_valid) begin n_err++; $display("FAIL qfull_ifid[%0d]: got %h@%h v%b expected %h@%h v%b", i, instr, pc, valid, m_instr, m_ifpc, m_valid); end
      n_vec++; if (obs_req !== exp_req || obs_addr !== exp_addr) begin n_err++; $display("FAIL qfull_req2[%0d]: got req=%b addr=%h expected req=%b addr=%h", i, obs_req, obs_addr, exp_req, exp_addr); end
    end
  endtask

  task automatic test_redirect_wait();
    bit seen;
    lat_lo = 3; lat_hi = 3; gnt_pct = 100;
    for (int k = 0; k < 12 && !(m_out && !m_stale && mem_pend && mem_cnt > 1); k++) step();
    n_vec++; if (!(m_out && !m_stale)) begin n_err++; $display("FAIL rdw_setup: got no outstanding fetch expected one (timeout)"); end
    pcsrc = 1'b1; flush_d = 1'b1; target = 32'h200;
    step();
    pcsrc = 1'b0; flush_d = 1'b0;
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL rdw_empty: got %b expected 1", empty); end
    n_vec++; if (valid !== 1'b0 || instr !== NOP) begin n_err++; $display("FAIL rdw_bubble: got %h v%b expected %h v0", instr, valid, NOP); end
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      step();
      n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL rdw_stale[%0d]: got valid=%b pc=%h expected valid=0", k, valid, pc); end
      if (obs_req) begin
        seen = 1'b1;
        n_vec++; if (obs_addr !== 32'h200) begin n_err++; $display("FAIL rdw_addr: got %h expected 200", obs_addr); end
      end
    end
    n_vec++; if (!seen) begin n_err++; $display("FAIL rdw_req: got no request expected one (timeout)"); end
    for (int k = 0; k < 10 && valid !== 1'b1; k++) step();
    n_vec++; if (valid !== 1'b1 || pc !== 32'h200 || instr !== mem_word(32'h200)) begin n_err++; $display("FAIL rdw_word: got %h@%h v%b expected %h@200 v1", instr, pc, valid, mem_word(32'h200)); end
  endtask

  task automatic test_redirect_grant();
    bit seen;
    lat_lo = 2; lat_hi = 2; gnt_pct = 0;
    for (int k = 0; k < 12 && !(!m_out && !mem_pend && m_q.size() < 2); k++) step();
    n_vec++; if (m_out || mem_pend) begin n_err++; $display("FAIL rdg_setup: got busy fetch expected idle REQ (timeout)"); end
    pcsrc = 1'b1; flush_d = 1'b1; target = 32'h300; force_gnt = 1'b1;
    step();
    pcsrc = 1'b0; flush_d = 1'b0; force_gnt = 1'b0; gnt_pct = 100;
    n_vec++; if (obs_req !== 1'b0) begin n_err++; $display("FAIL rdg_req_low: got %b expected 0", obs_req); end
    n_vec++; if (empty !== 1'b1 || valid !== 1'b0) begin n_err++; $display("FAIL rdg_clear: got empty=%b valid=%b expected 1/0", empty, valid); end
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      step();
      n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL rdg_stale[%0d]: got valid=%b pc=%h expected valid=0", k, valid, pc); end
      if (obs_req) begin
        seen = 1'b1;
        n_vec++; if (obs_addr !== 32'h300) begin n_err++; $display("FAIL rdg_addr: got %h expected 300", obs_addr); end
      end
    end
    n_vec++; if (!seen) begin n_err++; $display("FAIL rdg_req: got no request expected one (timeout)"); end
    for (int k = 0; k < 10 && valid !== 1'b1; k++) step();
    n_vec++; if (valid !== 1'b1 || pc !== 32'h300 || instr !== mem_word(32'h300)) begin n_err++; $display("FAIL rdg_word: got %h@%h v%b expected %h@300 v1", instr, pc, valid, mem_word(32'h300)); end
  endtask

  task automatic test_flush_stall();
    int n_q, n_pop;
    lat_lo = 1; lat_hi = 1; gnt_pct = 100;
    stall_d = 1'b1;
    for (int k = 0; k < 12 && !(m_q.size() >= 1 && !m_out); k++) step();
    stall_f = 1'b1;
    n_q = m_q.size();
    n_vec++; if (n_q < 1 || empty !== 1'b0) begin n_err++; $display("FAIL fs_setup: got empty=%b expected non-empty (timeout)", empty); end
    flush_d = 1'b1;
    step();
    flush_d = 1'b0; stall_d = 1'b0;
    n_vec++; if (instr !== NOP || valid !== 1'b0 || pc !== 32'h0 || pc4 !== 32'h4) begin n_err++; $display("FAIL fs_bubble: got %h@%h/%h v%b expected %h@0/4 v0", instr, pc, pc4, valid, NOP); end
    n_vec++; if (empty !== 1'b0) begin n_err++; $display("FAIL fs_count: got empty=%b expected 0", empty); end
    n_pop = 0;
    for (int k = 0; k < n_q + 2; k++) begin
      step();
      if (valid === 1'b1) n_pop++;
    end
    n_vec++; if (n_pop != n_q) begin n_err++; $display("FAIL fs_drain: got %0d words expected %0d", n_pop, n_q); end
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL fs_empty: got %b expected 1", empty); end
    stall_f = 1'b0;
  endtask

  task automatic test_random();
    gnt_pct = 70; lat_lo = 1; lat_hi = 3;
    for (int i = 0; i < 400; i++) begin
      stall_f = ($urandom_range(4) == 0);
      stall_d = ($urandom_range(5) == 0);
      pcsrc   = ($urandom_range(14) == 0);
      flush_d = pcsrc | ($urandom_range(9) == 0);
      target  = ($urandom_range(3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFC);
      step();
      n_vec++; if (obs_req !== exp_req || obs_addr !== exp_addr) begin n_err++; $display("FAIL rnd_req[%0d]: got req=%b addr=%h expected req=%b addr=%h", i, obs_req, obs_addr, exp_req, exp_addr); end
      n_vec++; if (instr !== m_instr || pc !== m_ifpc || pc4 !== m_ifpc + 32'd4 || valid !== m_valid) begin n_err++; $display("FAIL rnd_ifid[%0d]: got %h@%h/%h v%b expected %h@%h/%h v%b", i, instr, pc, pc4, valid, m_instr, m_ifpc, m_ifpc + 32'd4, m_valid); end
      n_vec++; if (empty !== (m_q.size() == 0)) begin n_err++; $display("FAIL rnd_empty[%0d]: got %b expected %b", i, empty, m_q.size() == 0); end
      if (i == 200) begin
        rst_n = 1'b0;
        #1;
        m_reset();
        n_vec++; if (valid !== 1'b0 || instr !== NOP || empty !== 1'b1 || addr !== RST_PC) begin n_err++; $display("FAIL rnd_reset: got %h v%b e%b addr=%h expected %h v0 e1 addr=%h", instr, valid, empty, addr, NOP, RST_PC); end
        #1 rst_n = 1'b1;
      end
    end
    stall_f = 1'b0; stall_d = 1'b0; pcsrc = 1'b0; flush_d = 1'b0;
  endtask

  initial begin
    m_reset();
    test_reset();
    test_first_fetch();
    test_stall();
    test_queue_full();
    test_redirect_wait();
    test_redirect_grant();
    test_flush_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch front end of the 5-stage RV32I pipeline. It owns the PC register, issues requests on the instruction-memory request/grant/response interface and buffers returned words in a 2-entry queue. It drives the IF/ID pipeline register and acts on the stall, flush and redirect controls produced by the hazard unit. Redirected or flushed fetches are discarded, including responses already in flight.

## Interface
- RESET_PC, 32'h0000_0000, PC value fetched first after reset
- NOP_INSTR, 32'h0000_0013, bubble word (addi x0,x0,0) loaded into IF/ID
- i_clk  in  1  clock; all state updates on rising edge
- i_rst_n  in  1  reset; asynchronous, active-low
- i_stall_f  in  1  freeze request issue (load-use stall)
- i_stall_d  in  1  hold IF/ID contents
- i_flush_d  in  1  load bubble into IF/ID
- i_pcsrc_e  in  1  branch/jump taken in EX; redirect fetch
- i_pc_target_e  in  32  redirect target
- o_imem_req  out  1  request valid
- o_imem_addr  out  32  word address (always pc_f, bits[1:0]=0)
- i_imem_gnt  in  1  request accepted this cycle
- i_imem_rvalid  in  1  response data valid
- i_imem_rdata  in  32  response instruction word
- o_if_id_instr  out  32  IF/ID instruction
- o_if_id_pc  out  32  IF/ID PC
- o_if_id_pc4  out  32  IF/ID PC+4
- o_if_id_valid  out  1  IF/ID holds a real instruction
- o_fetch_empty  out  1  queue empty (no instruction ready)

## Operation
- **FSM states.**
  - REQ: o_imem_req = (count<2) & ~i_stall_f & ~i_pcsrc_e. On req&gnt: pc_f += 4, go to WAIT.
  - WAIT: exactly one request is outstanding and o_imem_req=0. On rvalid: push {pc_fetched, rdata} into the queue and go to REQ.
  - DROP: o_imem_req=0. The next rvalid is discarded, then go to REQ.
- **Redirect (i_pcsrc_e=1):** pc_f <= i_pc_target_e and the queue is cleared, both at the same edge.
  - From REQ with no grant: stay in REQ.
  - From REQ with a grant the same cycle: go to DROP. The granted request belongs to the old path.
  - From WAIT without rvalid: go to DROP.
  - From WAIT with rvalid the same cycle: discard the word and go to REQ.
  - From DROP: stay in DROP until rvalid arrives.
- **Queue:** 2-entry FIFO of {pc, instr}, 2-bit count, 1-bit read/write pointers that wrap. A push and a pop in the same cycle leave count unchanged. A push never occurs at count=2, because only one request is outstanding and issue requires count<2.
- **IF/ID update, in priority order:**
  1. i_flush_d: load the bubble (NOP_INSTR, pc=0, pc4=4, valid=0). Any same-cycle pop is suppressed.
  2. i_stall_d: hold IF/ID and do not pop.
  3. Queue non-empty: pop the head. IF/ID gets its instr and pc, pc4=pc+4 (32-bit wrap), valid=1.
  4. Queue empty: load the bubble.
- **Redirect and IF/ID:** a redirect does not itself touch IF/ID. Flushing IF/ID is the role of i_flush_d, which the hazard unit asserts alongside i_pcsrc_e. When i_pcsrc_e is set, the queue clear overrides any pop.
- **Output mapping:** o_fetch_empty = (count==0).

## Timing
- **Reset values:**
  - pc_f = RESET_PC, state REQ, count 0, pointers 0.
  - IF/ID holds the bubble (instr 0x00000013, pc 0, pc4 4, valid 0).
  - o_imem_req rises combinationally in the first cycle after reset is released.
- **Mid-operation reset:** all state is forced immediately, and any in-flight response arriving after reset release is ignored. Only WAIT/DROP accept rvalid; rvalid in REQ is ignored.
- **Latency:** a grant at edge N and rvalid in cycle N+1 puts the word in the queue at edge N+1 and in IF/ID at edge N+2. With zero-wait memory, throughput is 1 instruction per 2 cycles.
- **Output registering:** IF/ID outputs are registered. o_imem_req and o_imem_addr are combinational from state, pc_f, count and the inputs.

## Test plan
- **Reset and first fetch.** Release reset with RESET_PC=0x100, gnt=1, rvalid one cycle after each grant, rdata=0xAABBCCDD. Required: o_imem_addr=0x100 in the first cycle; then IF/ID shows instr 0xAABBCCDD, pc 0x100, pc4 0x104, valid=1; the next request address is 0x104.
- **Stall.** Hold i_stall_d=1 and i_stall_f=1 for 3 cycles with the queue at count 1. Required: IF/ID unchanged, no request issued, count stays 1; after release, fetch resumes at the next sequential PC.
- **Queue full.** Hold i_stall_d=1 until count=2. Required: o_imem_req=0 while count=2; after release, the two queued instructions drain in PC order.
- **Redirect while waiting.** Redirect to 0x200 while in WAIT and before rvalid. Required: the stale response is discarded, the queue is empty, and the next request address is 0x200 with no stale word ever reaching IF/ID.
- **Redirect coinciding with grant.** Assert i_pcsrc_e together with gnt in REQ. Required: the FSM enters DROP, the stale word is dropped, and the following request address is the redirect target.
- **Flush with stall.** Assert i_flush_d together with i_stall_d. Required: IF/ID becomes the bubble (0x00000013, valid=0) and count is unchanged.
